// File: rtl/aes_pkg.sv
// Shared types and helpers for blocks that arbitrate access to the AES-128 core.
// rr_pick is the round-robin search reused by every shared-resource arbiter.
package aes_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int AES_KEY_W   = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  // First set bit of req at or above ptr, wrapping modulo n (n <= 8).
  // Returns ptr when no bit is set; callers qualify with |req.
  function automatic logic [2:0] rr_pick(input logic [7:0] req,
                                         input logic [2:0] ptr,
                                         input int         n);
    logic [2:0] idx;
    int         j;
    idx = ptr;
    for (int k = 7; k >= 0; k--) begin
      if (k < n) begin
        j = int'(ptr) + k;
        if (j >= n) j = j - n;
        if (req[j]) idx = 3'(j);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter_comb.sv
// Combinational round-robin picker: lowest requester at or after ptr, wrapping.
module rr_arbiter_comb
  import aes_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [2:0]         ptr,
  output logic [2:0]         idx,
  output logic               any
);

  logic [7:0] req_ext;

  always_comb begin
    req_ext              = '0;
    req_ext[NUM_REQ-1:0] = req;
  end

  assign idx = rr_pick(req_ext, ptr, NUM_REQ);
  assign any = |req;

endmodule

// File: rtl/aes_core_arbiter.sv
// Shares one AES-128 encrypt core between NUM_REQ requesters, one block in
// flight, round-robin grant, with a watchdog that answers with an error.
//
// state | meaning
// IDLE  | no block in flight; grant the next requester and capture its data
// ISSUE | pulse aes_start, arm the watchdog
// WAIT  | wait for aes_done or watchdog expiry
// RESP  | pulse resp_valid to the granted requester, advance rr_ptr
module aes_core_arbiter
  import aes_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*AES_BLOCK_W-1:0] req_plaintext,
  input  logic [NUM_REQ*AES_KEY_W-1:0]   req_key,
  output logic [NUM_REQ-1:0]             resp_valid,
  output logic                           resp_err,
  output logic [AES_BLOCK_W-1:0]         resp_ciphertext,
  output logic                           busy,
  output logic [2:0]                     grant_id,
  output logic                           aes_start,
  input  logic                           aes_done,
  output logic [AES_BLOCK_W-1:0]         aes_plaintext,
  output logic [AES_KEY_W-1:0]           aes_key,
  input  logic [AES_BLOCK_W-1:0]         aes_ciphertext
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  arb_state_t       state;
  logic [2:0]       rr_ptr;
  logic [2:0]       pick_idx;
  logic             pick_any;
  logic [CNT_W-1:0] tmo_cnt;

  rr_arbiter_comb #(
    .NUM_REQ(NUM_REQ)
  ) u_rr (
    .req(req_valid),
    .ptr(rr_ptr),
    .idx(pick_idx),
    .any(pick_any)
  );

  // Watchdog counts down from TIMEOUT_CYCLES-1; reaching zero in WAIT is the
  // TIMEOUT_CYCLES-th WAIT cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= IDLE;
      rr_ptr          <= '0;
      grant_id        <= '0;
      aes_plaintext   <= '0;
      aes_key         <= '0;
      tmo_cnt         <= '0;
      resp_ciphertext <= '0;
      resp_err        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant_id      <= pick_idx;
            aes_plaintext <= req_plaintext[int'(pick_idx)*AES_BLOCK_W +: AES_BLOCK_W];
            aes_key       <= req_key[int'(pick_idx)*AES_KEY_W +: AES_KEY_W];
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          tmo_cnt <= CNT_W'(TIMEOUT_CYCLES - 1);
          state   <= WAIT;
        end
        WAIT: begin
          if (aes_done) begin
            resp_ciphertext <= aes_ciphertext;
            resp_err        <= 1'b0;
            state           <= RESP;
          end else if (tmo_cnt == '0) begin
            resp_ciphertext <= '0;
            resp_err        <= 1'b1;
            state           <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt - 1'b1;
          end
        end
        RESP: begin
          rr_ptr <= (grant_id == 3'(NUM_REQ - 1)) ? 3'd0 : grant_id + 3'd1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    resp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      resp_valid[i] = (state == RESP) && (grant_id == 3'(i));
    end
  end

  assign aes_start = (state == ISSUE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Scoreboard bench for aes_core_arbiter with a behavioural core of fixed latency.
module tb_aes_core_arbiter;
  import aes_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int TMO     = 16;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic                   clk;
  logic                   rst;
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ*128-1:0] req_plaintext;
  logic [NUM_REQ*128-1:0] req_key;
  logic [NUM_REQ-1:0]     resp_valid;
  logic                   resp_err;
  logic [127:0]           resp_ciphertext;
  logic                   busy;
  logic [2:0]             grant_id;
  logic                   aes_start;
  logic                   aes_done;
  logic [127:0]           aes_plaintext;
  logic [127:0]           aes_key;
  logic [127:0]           aes_ciphertext;

  aes_core_arbiter #(
    .NUM_REQ(NUM_REQ),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_plaintext(req_plaintext),
    .req_key(req_key),
    .resp_valid(resp_valid),
    .resp_err(resp_err),
    .resp_ciphertext(resp_ciphertext),
    .busy(busy),
    .grant_id(grant_id),
    .aes_start(aes_start),
    .aes_done(aes_done),
    .aes_plaintext(aes_plaintext),
    .aes_key(aes_key),
    .aes_ciphertext(aes_ciphertext)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int           idx;
    logic [127:0] ct;
    logic         err;
  } exp_t;

  exp_t sb[$];
  int   start_log[$];
  int   checks    = 0;
  int   errors    = 0;
  int   model_en  = 1;
  int   model_lat = 11;
  bit   mon_en    = 0;

  // Stand-in core: the FIPS-197 vector maps to its known ciphertext, any
  // other block encrypts to pt ^ key so expected values stay hand-checkable.
  function automatic logic [127:0] core_fn(input logic [127:0] pt, input logic [127:0] key);
    if (pt == FIPS_PT && key == FIPS_KEY) return FIPS_CT;
    return pt ^ key;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Core model: sees aes_start in the ISSUE cycle, answers model_lat cycles later.
  initial begin
    logic [127:0] pt, key;
    int           lat;
    aes_done       = 1'b0;
    aes_ciphertext = '0;
    forever begin
      @(negedge clk);
      if (aes_start === 1'b1) begin
        start_log.push_back(int'(grant_id));
        if (model_en != 0) begin
          pt  = aes_plaintext;
          key = aes_key;
          lat = model_lat;
          repeat (lat) @(posedge clk);
          #1;
          aes_done       = 1'b1;
          aes_ciphertext = core_fn(pt, key);
          @(posedge clk);
          #1;
          aes_done       = 1'b0;
          aes_ciphertext = '0;
        end
      end
    end
  end

  // Monitor: every response pops the next expected entry.
  initial begin
    exp_t               e;
    logic [NUM_REQ-1:0] oh;
    forever begin
      @(negedge clk);
      if (mon_en && resp_valid !== '0) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: got resp_valid %b expected none", resp_valid);
        end else begin
          e         = sb.pop_front();
          oh        = '0;
          oh[e.idx] = 1'b1;
          chk("resp_route", 128'(resp_valid), 128'(oh));
          chk("resp_ct", resp_ciphertext, e.ct);
          chk("resp_err", 128'(resp_err), 128'(e.err));
        end
      end
    end
  end

  task automatic set_req(input int i, input logic [127:0] pt, input logic [127:0] key);
    req_plaintext[i*128 +: 128] = pt;
    req_key[i*128 +: 128]       = key;
    req_valid[i]                = 1'b1;
  endtask

  task automatic wait_resp(input int i);
    bit seen;
    seen = 0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (resp_valid[i] === 1'b1) seen = 1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL resp_wait_req%0d: got no resp_valid expected one within 200 cycles", i);
    end
    @(posedge clk);
    #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_start();
    bit seen;
    seen = 0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      if (aes_start === 1'b1) seen = 1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL start_wait: got no aes_start expected one within 50 cycles");
    end
  endtask

  // Negedges from the ISSUE cycle until resp_valid is seen.
  task automatic cycles_to_resp(output int n);
    bit seen;
    seen = 0;
    n    = 0;
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      if (resp_valid !== '0) seen = 1;
    end
  endtask

  initial begin
    int n;
    int bad;
    int exp_order[4];
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  initial begin
    int n;
    int bad;
    rst           = 1'b0;
    req_valid     = '0;
    req_plaintext = '0;
    req_key       = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_start", 128'(aes_start), 128'(0));
    chk("rst_resp_valid", 128'(resp_valid), 128'(0));
    chk("rst_grant_id", 128'(grant_id), 128'(0));
    chk("rst_aes_pt", aes_plaintext, 128'(0));
    chk("rst_resp_ct", resp_ciphertext, 128'(0));
    chk("rst_resp_err", 128'(resp_err), 128'(0));
    @(posedge clk);
    #1;
    rst    = 1'b1;
    mon_en = 1;

    // Single request on the FIPS-197 vector.
    @(posedge clk);
    #1;
    set_req(0, FIPS_PT, FIPS_KEY);
    sb.push_back('{idx: 0, ct: FIPS_CT, err: 1'b0});
    @(negedge clk);
    chk("start_not_early", 128'(aes_start), 128'(0));
    @(negedge clk);
    chk("start_latency", 128'(aes_start), 128'(1));
    chk("busy_issue", 128'(busy), 128'(1));
    chk("issue_key", aes_key, FIPS_KEY);
    bad = 1;
    for (int c = 0; c < 50 && bad != 0; c++) begin
      @(negedge clk);
      if (aes_done === 1'b1) bad = 0;
    end
    @(negedge clk);
    chk("resp_after_done", 128'(resp_valid), 128'(2'b01));
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("resp_one_cycle", 128'(resp_valid), 128'(0));
    chk("ct_hold", resp_ciphertext, FIPS_CT);

    // Timeout: core never answers; requester 1 is next in rotation.
    model_en = 0;
    @(posedge clk);
    #1;
    set_req(1, {4{32'h11111111}}, {4{32'h22222222}});
    sb.push_back('{idx: 1, ct: 128'(0), err: 1'b1});
    wait_start();
    cycles_to_resp(n);
    chk("timeout_cycles", 128'(n), 128'(TMO + 1));
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    model_en     = 1;
    @(negedge clk);
    chk("err_hold", 128'(resp_err), 128'(1));

    // aes_done in the same cycle the watchdog expires: done wins.
    model_lat = TMO;
    @(posedge clk);
    #1;
    set_req(0, {4{32'haaaaaaaa}}, {4{32'h55555555}});
    sb.push_back('{idx: 0, ct: {4{32'hffffffff}}, err: 1'b0});
    wait_start();
    cycles_to_resp(n);
    chk("simul_cycles", 128'(n), 128'(TMO + 1));
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    model_lat    = 11;

    // Reset in WAIT for requester 1 (rr_ptr is 1 here); core answers late.
    @(posedge clk);
    #1;
    set_req(1, {4{32'h11111111}}, {4{32'h22222222}});
    wait_start();
    repeat (3) @(posedge clk);
    #1;
    rst       = 1'b0;
    req_valid = '0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rstw_busy", 128'(busy), 128'(0));
    chk("rstw_resp_valid", 128'(resp_valid), 128'(0));
    chk("rstw_grant_id", 128'(grant_id), 128'(0));
    bad = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (resp_valid !== '0 || busy !== 1'b0) bad++;
    end
    chk("late_done_ignored", 128'(bad), 128'(0));

    // Contention: rr_ptr restarted at 0, so grants go 0,1,0,1.
    start_log.delete();
    sb.push_back('{idx: 0, ct: FIPS_CT, err: 1'b0});
    sb.push_back('{idx: 1, ct: {4{32'h33333333}}, err: 1'b0});
    sb.push_back('{idx: 0, ct: 128'hfedcba9876543210fedcba9876543210, err: 1'b0});
    sb.push_back('{idx: 1, ct: 128'h80000000000000000000000000000001, err: 1'b0});
    @(posedge clk);
    #1;
    fork
      begin
        set_req(0, FIPS_PT, FIPS_KEY);
        wait_resp(0);
        @(posedge clk);
        #1;
        set_req(0, 128'h0123456789abcdef0123456789abcdef, {4{32'hffffffff}});
        wait_resp(0);
      end
      begin
        set_req(1, {4{32'h11111111}}, {4{32'h22222222}});
        wait_resp(1);
        @(posedge clk);
        #1;
        set_req(1, 128'h1, 128'h80000000000000000000000000000000);
        wait_resp(1);
      end
    join
    chk("grant_count", 128'(start_log.size()), 128'(4));
    for (int k = 0; k < 4 && k < start_log.size(); k++) begin
      chk($sformatf("grant_order_%0d", k), 128'(start_log[k]), 128'(k % 2));
    end

    // Stability: data changed during WAIT must not reach the core.
    @(posedge clk);
    #1;
    set_req(0, {4{32'hdeadbeef}}, 128'(0));
    sb.push_back('{idx: 0, ct: {4{32'hdeadbeef}}, err: 1'b0});
    wait_start();
    repeat (2) @(posedge clk);
    #1;
    req_plaintext[127:0] = '0;
    req_key[127:0]       = {4{32'hffffffff}};
    @(negedge clk);
    chk("pt_stable", aes_plaintext, {4{32'hdeadbeef}});
    chk("key_stable", aes_key, 128'(0));
    wait_resp(0);

    repeat (3) @(negedge clk);
    chk("sb_empty", 128'(sb.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
